// File: rtl/rv_core_pkg.sv
// Shared core types: data width, bubble encoding, fetch FSM states and the
// IF/ID pipeline record.
package rv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register for an if_id_t record with load, flush and hold.
// Flush inserts a bubble but keeps the pc fields for debug visibility.
module if_id_reg
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values,
        // independent of statement order within or across blocks.
        if (reset) begin
            q.valid    <= 1'b0;
            q.pc       <= '0;
            q.instr    <= BUBBLE;
            q.pc_plus4 <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem read
// and fills the IF/ID register, with stall, redirect/flush and sticky fault.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 32,
    parameter logic [31:0] NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault
);

    import rv_core_pkg::*;

    // Highest word-aligned address that still fits a full 32-bit fetch.
    localparam logic [XLEN-1:0] PC_LAST = MEM_BYTES - 32'd4;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next, pc_plus4;
    logic            load, flush, pc_illegal;
    if_id_t          fetch_word, id_q;

    assign pc_plus4   = pc + 32'd4;
    assign pc_illegal = (pc[1:0] != 2'b00) || (pc > PC_LAST);
    assign fetch_word = '{valid: 1'b1, pc: pc, instr: imem_instr, pc_plus4: pc_plus4};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        unique case (state)
            FILL: state_next = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    flush   = 1'b1;
                end else if (!stall) begin
                    if (pc_illegal) begin
                        state_next = FAULT;
                        flush      = 1'b1;
                    end else begin
                        load    = 1'b1;
                        pc_next = pc_plus4;
                    end
                end
            end
            FAULT: ;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    if_id_reg #(
        .BUBBLE(NOP_INSTR)
    ) u_if_id (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .flush(flush),
        .d    (fetch_word),
        .q    (id_q)
    );

    // FAULT is only left through reset, so the state itself is the sticky flag.
    assign fetch_fault = (state == FAULT);
    assign imem_addr   = pc;
    assign id_valid    = id_q.valid;
    assign id_pc       = id_q.pc;
    assign id_instr    = id_q.instr;
    assign id_pc_plus4 = id_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts the IF/ID
// contents per edge, directed checks pin the documented scenarios.
module tb_fetch_stage;

    import rv_core_pkg::*;

    localparam int unsigned MEM_BYTES = 32;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_target, imem_addr, imem_instr;
    logic        id_valid, fetch_fault;
    logic [31:0] id_pc, id_instr, id_pc_plus4;

    logic [7:0]  mem [MEM_BYTES];
    logic [31:0] image [8];

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        fault;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_steps  = 0;

    fetch_state_t m_state;
    logic [31:0]  m_pc, m_ipc, m_ins, m_p4;
    logic         m_v, m_flt;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(MEM_BYTES),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    // Little-endian byte-addressed instruction memory, combinational read.
    always_comb begin
        imem_instr = 32'h0;
        if (imem_addr <= 32'(MEM_BYTES - 4))
            imem_instr = {mem[imem_addr[4:0] + 5'd3], mem[imem_addr[4:0] + 5'd2],
                          mem[imem_addr[4:0] + 5'd1], mem[imem_addr[4:0]]};
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h0;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = mem[int'(a) + b];
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic rv,
                              input logic [31:0] tgt);
        if (rst) begin
            m_state = FILL; m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0;
            m_ins = NOP; m_p4 = 32'h0; m_flt = 1'b0;
        end else begin
            case (m_state)
                FILL: m_state = RUN;
                RUN: begin
                    if (rv) begin
                        m_pc = tgt; m_v = 1'b0; m_ins = NOP;
                    end else if (!st) begin
                        if (m_pc[1:0] != 2'b00 || ({32'd0, m_pc} + 64'd4 > 64'(MEM_BYTES))) begin
                            m_state = FAULT; m_flt = 1'b1; m_v = 1'b0; m_ins = NOP;
                        end else begin
                            m_v = 1'b1; m_ipc = m_pc; m_ins = word_at(m_pc);
                            m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock edge: drive inputs, push the prediction, compare after the edge.
    task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
        model_edge(rst, st, rv, tgt);
        e = '{valid: m_v, pc: m_ipc, instr: m_ins, pc_plus4: m_p4, fault: m_flt, addr: m_pc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL s%0d_scoreboard: got empty queue, expected an entry", n_steps);
        end else begin
            e = sb.pop_front();
            check($sformatf("s%0d_id_valid", n_steps), id_valid, e.valid);
            check($sformatf("s%0d_id_pc", n_steps), id_pc, e.pc);
            check($sformatf("s%0d_id_instr", n_steps), id_instr, e.instr);
            check($sformatf("s%0d_id_pc_plus4", n_steps), id_pc_plus4, e.pc_plus4);
            check($sformatf("s%0d_fetch_fault", n_steps), fetch_fault, e.fault);
            check($sformatf("s%0d_imem_addr", n_steps), imem_addr, e.addr);
        end
        n_steps++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        image = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4011_0233,
                  32'h0032_2023, 32'h0002_A283, 32'h0013_8463, 32'h4023_83B3};
        for (int w = 0; w < 8; w++)
            for (int b = 0; b < 4; b++)
                mem[4*w + b] = image[w][8*b +: 8];
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

        // Reset and fill bubble, then sequential fetch.
        repeat (3) step(1, 0, 0, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_imem_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0);
        check("fill_bubble", id_valid, 0);
        step(0, 0, 0, 0);
        check("f0_pc", id_pc, 32'h00);
        check("f0_instr", id_instr, 32'h0050_0093);
        step(0, 0, 0, 0);
        check("f1_pc", id_pc, 32'h04);
        check("f1_instr", id_instr, 32'h00A0_0113);

        // Stall holds PC and IF/ID.
        repeat (2) step(0, 1, 0, 0);
        check("stall_id_pc", id_pc, 32'h04);
        check("stall_instr", id_instr, 32'h00A0_0113);
        check("stall_addr", imem_addr, 32'h08);
        step(0, 0, 0, 0);
        check("post_stall_pc", id_pc, 32'h08);
        check("post_stall_instr", id_instr, 32'h0020_81B3);

        // Redirect: one bubble, then target.
        step(0, 0, 1, 32'h18);
        check("redir_bubble_valid", id_valid, 0);
        check("redir_bubble_instr", id_instr, NOP);
        step(0, 0, 0, 0);
        check("redir_pc", id_pc, 32'h18);
        check("redir_instr", id_instr, 32'h0013_8463);
        check("redir_plus4", id_pc_plus4, 32'h1C);

        // Redirect beats stall.
        step(0, 1, 1, 32'h04);
        check("rs_bubble", id_valid, 0);
        step(0, 0, 0, 0);
        check("rs_pc", id_pc, 32'h04);
        check("rs_instr", id_instr, 32'h00A0_0113);

        // Run off the end of memory into FAULT.
        repeat (6) step(0, 0, 0, 0);
        check("last_pc", id_pc, 32'h1C);
        check("last_instr", id_instr, 32'h4023_83B3);
        step(0, 0, 0, 0);
        check("oob_fault", fetch_fault, 1);
        check("oob_valid", id_valid, 0);
        check("oob_addr", imem_addr, 32'h20);
        step(0, 0, 1, 32'h00);
        check("fault_ignores_redir", imem_addr, 32'h20);
        step(0, 1, 0, 0);

        // Reset out of FAULT, then misaligned redirect target.
        step(1, 0, 0, 0);
        check("fault_reset_flag", fetch_fault, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0A);
        check("mis_bubble", id_valid, 0);
        step(0, 1, 0, 0);
        check("mis_stall_no_fault", fetch_fault, 0);
        step(0, 0, 0, 0);
        check("mis_fault", fetch_fault, 1);
        check("mis_addr", imem_addr, 32'h0A);
        step(1, 1, 1, 32'h10);
        check("mis_reset_flag", fetch_fault, 0);
        check("mis_reset_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0);
        check("refill_bubble", id_valid, 0);
        step(0, 0, 0, 0);
        check("refetch_pc", id_pc, 32'h00);
        check("refetch_instr", id_instr, 32'h0050_0093);

        // Random mix against the model.
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, 32'($urandom_range(0, 35)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the memory read address; the memory read is combinational.
- Captures the returned little-endian 32-bit word into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect with flush, and a sticky fetch-fault halt for out-of-range or misaligned PCs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_BYTES, 32, instruction memory size in bytes; legal fetch requires pc + 4 <= MEM_BYTES.
NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) placed in id_instr on flush or reset.

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high; also holds the instruction memory in its load phase.
stall  in  1  hazard unit request to hold the PC and the IF/ID register.
redirect_valid  in  1  taken branch or jump resolved downstream.
redirect_target  in  32  new PC when redirect_valid=1.
imem_addr  out  32  byte address to instruction memory; equals the pc register.
imem_instr  in  32  word returned by instruction memory for imem_addr, same cycle.
id_valid  out  1  IF/ID register holds a real instruction.
id_pc  out  32  PC of the instruction in id_instr.
id_instr  out  32  captured instruction.
id_pc_plus4  out  32  id_pc + 4, registered with the rest of IF/ID.
fetch_fault  out  1  sticky; set on an illegal fetch PC.

Behaviour:
- Reset, applied on any edge with reset=1:
  - pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_pc_plus4=0, fetch_fault=0.
  - state=FILL.
- imem_addr = pc, combinational from the register; no other logic in the path.
- FSM states FILL, RUN, FAULT:
  - FILL: one bubble edge after reset releases, because memory contents settle during reset. id_valid stays 0, pc holds, next state RUN. Stall and redirect are ignored.
  - RUN, priority order per edge:
    - redirect_valid=1: pc <= redirect_target; id_valid <= 0; id_instr <= NOP_INSTR; id_pc and id_pc_plus4 hold. Redirect beats stall.
    - else stall=1: pc and all IF/ID outputs hold their values.
    - else if the pc is illegal (pc[1:0] != 0, or pc > MEM_BYTES-4, compared unsigned in 32 bits): state <= FAULT; fetch_fault <= 1; id_valid <= 0; id_instr <= NOP_INSTR; pc holds.
    - else normal fetch: id_valid <= 1; id_pc <= pc; id_instr <= imem_instr; id_pc_plus4 <= pc+4; pc <= pc+4.
  - FAULT: all registers hold; stall and redirect are ignored; only reset exits.
- Latency: an instruction at PC p appears on id_* one edge after pc==p in RUN with no stall.
- Redirect penalty: exactly one bubble, then the target instruction appears on the following edge.
- Misaligned redirect target: accepted into pc; the fault is raised on the next non-stalled RUN edge.
- Arithmetic: pc+4 is 32-bit modulo 2^32. Wrap-around is unreachable because the range check faults first.
- Reset asserted mid-stall, mid-redirect or in FAULT: reset wins on that edge and returns to the full reset state.

Decomposition:
- Package rv_core_pkg holds: XLEN=32, NOP_INSTR constant, fetch_state_t enum {FILL, RUN, FAULT}, and the if_id_t struct {valid, pc, instr, pc_plus4}.
- One sub-module, if_id_reg: the IF/ID register with load, flush and hold controls, reused later for ID/EX.
- PC, FSM and legality check stay in fetch_stage.

Test Plan:
1. Reset 3 cycles, release, run with MEM_BYTES=32 and the standard 8-instruction image -> edge 1 bubble (id_valid=0); then id_pc/id_instr = 0x00/0x00500093, 0x04/0x00A00113, 0x08/0x002081B3 on consecutive edges.
2. Assert stall for 2 cycles while id_pc=0x04 -> id_pc stays 0x04, id_instr stays 0x00A00113, imem_addr stays 0x08; release -> 0x08/0x002081B3.
3. redirect_valid=1 with target 0x18 while id_pc=0x08 -> next edge id_valid=0 and id_instr=0x00000013; following edge id_pc=0x18, id_instr=0x00138463, id_pc_plus4=0x1C.
4. redirect and stall asserted together with target 0x04 -> redirect wins: bubble, then 0x04/0x00A00113.
5. Let execution run past 0x1C -> id_pc=0x1C with id_instr=0x402383B3; next edge fetch_fault=1, id_valid=0, imem_addr stays 0x20; later redirects ignored.
6. Redirect to 0x0A -> bubble, then fetch_fault=1; assert reset -> fetch_fault=0, pc=0x00, FILL bubble, then 0x00/0x00500093.
